// File: rtl/b1_dec_scan.sv
// b1_dec_scan: registered 4-to-16 one-hot decoder with a pipelined
// accept path and a dwell-timed 0..15 output scan.
module b1_dec_scan #(
    parameter int unsigned DWELL = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  binary_in,
    input  logic        in_valid,
    input  logic        scan_start,
    input  logic        scan_abort,
    output logic [15:0] out,
    output logic        out_valid,
    output logic        scan_busy,
    output logic        scan_done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [7:0] DWELL_N = 8'(DWELL);

    state_t      state;
    logic        s1_valid;
    logic [3:0]  s1_code;
    logic        s2_valid;
    logic [15:0] s2_data;
    logic [3:0]  code;
    logic [7:0]  dwell;

    function automatic logic [15:0] onehot(input logic [3:0] c);
        onehot = 16'h0001 << c;
    endfunction

    // Scan FSM, accept pipeline and registered outputs in one block.
    // The dwell counter counts cycles the current code has been shown.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            s1_valid  <= 1'b0;
            s1_code   <= 4'd0;
            s2_valid  <= 1'b0;
            s2_data   <= 16'h0000;
            code      <= 4'd0;
            dwell     <= 8'd0;
            out       <= 16'h0000;
            out_valid <= 1'b0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            scan_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (scan_start && !scan_abort) begin
                        state     <= SCAN;
                        scan_busy <= 1'b1;
                        code      <= 4'd0;
                        dwell     <= 8'd0;
                        s1_valid  <= 1'b0;
                        s2_valid  <= 1'b0;
                        if (!enable) out <= 16'h0000;
                    end else if (!enable) begin
                        s1_valid <= 1'b0;
                        s2_valid <= 1'b0;
                        out      <= 16'h0000;
                    end else begin
                        s1_valid <= in_valid;
                        s1_code  <= binary_in;
                        s2_valid <= s1_valid;
                        s2_data  <= onehot(s1_code);
                        if (s2_valid) begin
                            out       <= s2_data;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    s1_valid <= 1'b0;
                    s2_valid <= 1'b0;
                    if (scan_abort) begin
                        state     <= IDLE;
                        scan_busy <= 1'b0;
                        out       <= 16'h0000;
                        code      <= 4'd0;
                        dwell     <= 8'd0;
                    end else if (!enable) begin
                        out <= 16'h0000;
                    end else if (dwell == DWELL_N) begin
                        if (code == 4'd15) begin
                            state     <= DONE;
                            scan_busy <= 1'b0;
                            scan_done <= 1'b1;
                            out       <= 16'h0000;
                            code      <= 4'd0;
                            dwell     <= 8'd0;
                        end else begin
                            code  <= code + 4'd1;
                            dwell <= 8'd1;
                            out   <= onehot(code + 4'd1);
                        end
                    end else begin
                        out   <= onehot(code);
                        dwell <= dwell + 8'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    s1_valid <= 1'b0;
                    s2_valid <= 1'b0;
                    if (!enable) out <= 16'h0000;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_b1_dec_scan.sv
// tb_b1_dec_scan: directed checks of decode, streaming, enable kill,
// full scan, abort, pause and reset for b1_dec_scan.
module tb_b1_dec_scan;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  binary_in;
    logic        in_valid;
    logic        scan_start;
    logic        scan_abort;
    logic [15:0] out;
    logic        out_valid;
    logic        scan_busy;
    logic        scan_done;

    int total = 0;
    int bad = 0;

    b1_dec_scan #(.DWELL(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .binary_in  (binary_in),
        .in_valid   (in_valid),
        .scan_start (scan_start),
        .scan_abort (scan_abort),
        .out        (out),
        .out_valid  (out_valid),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic accept_one(input logic [3:0] c, input logic [15:0] e);
        binary_in = c;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("acc_early_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("acc_out", {16'd0, out}, {16'd0, e});
        chk("acc_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("acc_hold", {16'd0, out}, {16'd0, e});
        chk("acc_pulse_end", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        binary_in  = 4'd0;
        in_valid   = 1'b0;
        scan_start = 1'b0;
        scan_abort = 1'b0;
        tick();
        tick();
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, scan_busy}, 32'd0);
        chk("rst_done", {31'd0, scan_done}, 32'd0);
        reset = 1'b0;

        // single accepts
        accept_one(4'd5, 16'h0020);
        accept_one(4'd15, 16'h8000);
        accept_one(4'd0, 16'h0001);

        // streaming 0..15
        for (int i = 0; i < 18; i++) begin
            in_valid  = (i < 16);
            binary_in = 4'(i);
            tick();
            if (i >= 2) begin
                chk("stream_out", {16'd0, out}, 32'd1 << (i - 2));
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("stream_hold", {16'd0, out}, 32'h8000);
        chk("stream_idle", {31'd0, out_valid}, 32'd0);

        // enable kill
        binary_in = 4'd3;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        enable   = 1'b0;
        tick();
        chk("kill_out", {16'd0, out}, 32'd0);
        chk("kill_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("kill_valid2", {31'd0, out_valid}, 32'd0);
        enable = 1'b1;
        tick();
        tick();
        chk("kill_reen_out", {16'd0, out}, 32'd0);
        chk("kill_reen_valid", {31'd0, out_valid}, 32'd0);

        // full scan with stray in_valid pulses
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        chk("scan_busy_start", {31'd0, scan_busy}, 32'd1);
        for (int c = 0; c < 16; c++) begin
            for (int d = 0; d < 4; d++) begin
                in_valid  = (d == 1);
                binary_in = 4'd9;
                tick();
                chk("scan_out", {16'd0, out}, 32'd1 << c);
                chk("scan_valid", {31'd0, out_valid}, 32'd0);
                chk("scan_busy", {31'd0, scan_busy}, 32'd1);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("done_out", {16'd0, out}, 32'd0);
        chk("done_pulse", {31'd0, scan_done}, 32'd1);
        chk("done_busy", {31'd0, scan_busy}, 32'd0);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        chk("done_pulse_end", {31'd0, scan_done}, 32'd0);
        chk("done_no_queue", {31'd0, scan_busy}, 32'd0);
        tick();
        chk("done_no_queue2", {31'd0, scan_busy}, 32'd0);
        chk("post_scan_valid", {31'd0, out_valid}, 32'd0);
        accept_one(4'd1, 16'h0002);

        // abort at code 7
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int t = 0; t < 29; t++) tick();
        chk("abort_at7", {16'd0, out}, 32'h0080);
        scan_abort = 1'b1;
        tick();
        scan_abort = 1'b0;
        chk("abort_out", {16'd0, out}, 32'd0);
        chk("abort_busy", {31'd0, scan_busy}, 32'd0);
        chk("abort_done", {31'd0, scan_done}, 32'd0);
        tick();
        chk("abort_done2", {31'd0, scan_done}, 32'd0);

        // start and abort together in IDLE
        scan_start = 1'b1;
        scan_abort = 1'b1;
        tick();
        scan_start = 1'b0;
        scan_abort = 1'b0;
        chk("abort_wins", {31'd0, scan_busy}, 32'd0);

        // pause at code 2
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int t = 0; t < 9; t++) tick();
        chk("pause_at2", {16'd0, out}, 32'h0004);
        enable = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("pause_out", {16'd0, out}, 32'd0);
            chk("pause_busy", {31'd0, scan_busy}, 32'd1);
        end
        enable = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("resume_out", {16'd0, out}, 32'h0004);
        end
        tick();
        chk("resume_next", {16'd0, out}, 32'h0008);
        scan_abort = 1'b1;
        tick();
        scan_abort = 1'b0;

        // reset mid-scan at code 9
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int t = 0; t < 37; t++) tick();
        chk("rst_at9", {16'd0, out}, 32'h0200);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_out", {16'd0, out}, 32'd0);
        chk("midrst_busy", {31'd0, scan_busy}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_done", {31'd0, scan_done}, 32'd0);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        tick();
        chk("restart_out", {16'd0, out}, 32'h0001);
        chk("restart_busy", {31'd0, scan_busy}, 32'd1);
        scan_abort = 1'b1;
        tick();
        scan_abort = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/b1_dec_scan.md
B1_DEC_SCAN -- requirements
Module: b1_dec_scan

Interface
REQ-001 Parameter: DWELL, default 4, clock cycles each code is held during a scan; legal range 1..255.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  global enable; low forces out to 0.
REQ-005 binary_in  input  4  binary code to decode.
REQ-006 in_valid  input  1  binary_in is valid this cycle.
REQ-007 scan_start  input  1  one-cycle request to start a 0..15 output walk.
REQ-008 scan_abort  input  1  one-cycle request to terminate a scan.
REQ-009 out  output  16  registered one-hot decode result.
REQ-010 out_valid  output  1  one-cycle pulse: out was updated from an accepted input.
REQ-011 scan_busy  output  1  high while FSM is in SCAN.
REQ-012 scan_done  output  1  one-cycle pulse on normal scan completion.

Function
REQ-013 Two-stage pipeline (input register, output register); all outputs are driven from flops.
REQ-014 Decode: out = 1 << code; exactly one bit set when nonzero; no other encodings.
REQ-015 Accept: in IDLE, in_valid=1 and enable=1 at edge k captures binary_in; out updates and out_valid=1 after edge k+2.
REQ-016 Back-to-back accepts sustain one result per cycle, in order, no bubbles.
REQ-017 out_valid SHALL be high for exactly one cycle per accepted input; zero otherwise.
REQ-018 Hold: with no new result, out SHALL retain its last value.
REQ-019 enable=0 at any edge: output register loads 0, out_valid=0, stage-1 content discarded.
REQ-020 FSM states: IDLE, SCAN, DONE; reset state IDLE.
REQ-021 IDLE->SCAN: scan_start=1 and scan_abort=0 at edge k; stage-1 content discarded; code counter=0, dwell counter=0.
REQ-022 In SCAN, out = 1 << code from edge k+1; code held DWELL enabled cycles, then increments.
REQ-023 In SCAN, in_valid and scan_start are ignored; out_valid=0; scan_busy=1.
REQ-024 enable=0 in SCAN: counters pause, out=0; on enable=1, the scan resumes at the same code with the dwell count preserved.
REQ-025 After code 15 completes its dwell: SCAN->DONE; out=0 and scan_done=1 for that one cycle; DONE->IDLE next edge unconditionally.
REQ-026 scan_abort=1 in SCAN: ->IDLE at that edge, out=0, no scan_done pulse.
REQ-027 scan_start and scan_abort together in IDLE: abort wins, FSM stays IDLE.
REQ-028 Inputs in DONE are ignored; a scan_start there is not queued.
REQ-029 The code counter is 4-bit and SHALL NOT wrap during a scan; 15 is terminal.

Reset
REQ-030 reset=1 at an edge: out=0, out_valid=0, scan_busy=0, scan_done=0, FSM=IDLE, counters=0, pipeline flushed.
REQ-031 Reset SHALL override every other input, including mid-scan and mid-pipeline.
REQ-032 First accept is possible at the first edge with reset=0.

Verification
REQ-033 Directed decode: enable=1, in_valid=1, binary_in=5 at edge k -> out=0x0020, out_valid=1 after edge k+2; binary_in=15 -> 0x8000; binary_in=0 -> 0x0001.
REQ-034 Streaming: binary_in=0..15 on consecutive cycles -> out 0x0001..0x8000 on 16 consecutive cycles with out_valid continuously high; then in_valid=0 -> out holds 0x8000 and out_valid=0.
REQ-035 Enable kill: accept code 3, drop enable at edge k+1 -> out=0 and no out_valid pulse; re-enable -> out stays 0 until the next accept.
REQ-036 Full scan, DWELL=4: scan_start -> out walks 0x0001..0x8000, 4 cycles each (64 cycles), then scan_done=1 with out=0 for one cycle, then IDLE; in_valid pulses during the scan have no effect.
REQ-037 Abort/pause: abort at code 7 -> IDLE with out=0 and no scan_done; enable low 3 cycles at code 2 -> out=0, then code 2 resumes its remaining dwell.
REQ-038 Reset mid-scan at code 9 -> all outputs 0 and IDLE on the next edge; a fresh scan_start restarts at code 0.
